seq_alu: RTL and testbench
==========================

# seq_alu

Clocked, parametrised-width ALU with internal operand registers A and B, a valid/ready command handshake and registered status flags. It executes one opcode per accepted command: single-cycle ops for arithmetic, logic and register moves, and an optional multi-cycle signed multiply. It sits between the front-panel/command sequencer and the LED/result display path, and it is the next-generation clocked successor to the team's 8-bit combinational operator mux.

## Interface
- WIDTH, 8, datapath width in bits (≥4); A, B, result and data_in are all WIDTH bits, two's complement.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- op_valid  in  1  command present.
- op_ready  out  1  block can accept a command this cycle.
- opcode  in  4  operation select; sampled on accept.
- data_in  in  WIDTH  load operand; sampled on accept.
- result  out  WIDTH  registered result (Y).
- result_valid  out  1  one-cycle completion pulse.
- flags  out  4  {V,C,N,Z}; registered.
- illegal  out  1  pulses with result_valid when opcode unsupported.
- a_out, b_out  out  WIDTH each  current A and B (for LEDs).

## Operation
- Accept = op_valid && op_ready at a rising edge. op_ready=1 in IDLE, 0 in MUL.
- Opcode map:
  - 0 add A+B; 1 sub A−B; 2 shl A<<1; 3 sar A>>>1.
  - 4 cmp → +1 if A>B, 0 if equal, −1 if A<B (signed).
  - 5 and; 6 or; 7 xor; 8 nand; 9 nor; A not A.
  - B load B←data_in; C mul (signed A×B, low WIDTH bits); D store A←result; E swap A↔B; F load A←data_in.
- Result ops (0–A, C) update result and flags. Register ops (B, D, E, F) leave result/flags unchanged but still pulse result_valid.
- Flags:
  - Z = result==0; N = result MSB.
  - C = carry out (add), borrow (sub), bit shifted out (shl: old MSB, sar: old LSB), else 0.
  - V = signed overflow (add/sub/shl); for mul, 1 when the full 2·WIDTH product is not representable in WIDTH signed bits; else 0.
- FSM:
  - IDLE: on accept of a single-cycle op, stay in IDLE; on accept of mul, go to MUL.
  - MUL: performs an iterative shift-add over WIDTH cycles using a cycle counter, then returns to IDLE.
- Arithmetic wraps modulo 2^WIDTH; −(2^(WIDTH−1)) operands are legal (mul handles magnitude in WIDTH+1 bits).

## Timing
- Reset values: result=0, flags=0, A=B=0, result_valid=0, illegal=0, op_ready=1, state IDLE, counter 0.
- Single-cycle op accepted at edge k: A/B/result/flags updated at edge k; result_valid=1 during cycle k→k+1. Back-to-back accepts every cycle are allowed.
- mul accepted at edge k:
  - op_ready=0 from edge k.
  - Operands are snapshotted at edge k.
  - result/flags are written at edge k+WIDTH; result_valid=1 and op_ready=1 during cycle k+WIDTH→k+WIDTH+1.
- op_valid while op_ready=0 is ignored; the command is not queued.
- Store (D) immediately after an op uses the result registered at the previous edge.
- Reset asserted mid-mul aborts the operation: all state returns to reset values immediately, with no result_valid. op_ready=1 from the first edge after deassertion.

## Configuration
- SEQ_ALU_MUL_EN defined: opcode C is the multi-cycle multiply described above.
- SEQ_ALU_MUL_EN undefined: no MUL state or multiplier logic. Opcode C completes in one cycle with illegal=1 and result_valid=1; result, flags, A and B are unchanged; op_ready never drops.

## Test plan
- Reset, load A=0x7F (F), load B=0x01 (B), add → result 0x80, flags V=1, N=1, C=0, Z=0, result_valid pulse one cycle after each accept.
- A=0x05, B=0x05, cmp → 0x00, Z=1. Then A=0x80, B=0x01, cmp → 0xFF (−1). Then sar A=0x81 → 0xC0, C=1.
- With SEQ_ALU_MUL_EN, WIDTH=8: A=−3 (0xFD), B=7, mul → 0xEB (−21), V=0. The result appears exactly 8 cycles after accept, op_ready=0 throughout, and op_valid pulses in between are ignored. A=0x40, B=0x04 → 0x00, V=1, Z=1.
- A=0x12, B=0x34, swap → a_out=0x34, b_out=0x12, result unchanged. Then store → A=prior result.
- Assert reset at cycle 3 of a mul → all outputs 0, op_ready=1, no result_valid. Next add of loaded values behaves normally.
- Without SEQ_ALU_MUL_EN: opcode C → illegal=1 with result_valid the next cycle, result/A/B unchanged. Repeat at WIDTH=16: 0x7FFF+1 → 0x8000, V=1.

Source files
------------

// File: rtl/seq_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seq_alu : clocked ALU with A/B operand registers, valid/ready command port,  |
// |           registered {V,C,N,Z} flags. SEQ_ALU_MUL_EN adds iterative mul.     |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [3:0]       flags,
  output logic             illegal,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out
);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             valid_q, valid_d, illegal_q, illegal_d;
  logic             accept;

  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH-1:0] alu_y;
  logic             alu_v, alu_c, alu_upd;

  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_y   = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    alu_upd = (opcode <= 4'hA);
    case (opcode)
      4'h0: begin
        alu_y = sum_w[WIDTH-1:0];
        alu_c = sum_w[WIDTH];
        alu_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_y[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'h1: begin
        alu_y = diff_w[WIDTH-1:0];
        alu_c = diff_w[WIDTH];
        alu_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_y[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'h2: begin
        alu_y = {a_q[WIDTH-2:0], 1'b0};
        alu_c = a_q[WIDTH-1];
        alu_v = a_q[WIDTH-1] ^ a_q[WIDTH-2];
      end
      4'h3: begin
        alu_y = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        alu_c = a_q[0];
      end
      4'h4: begin
        if ($signed(a_q) > $signed(b_q))       alu_y = {{(WIDTH-1){1'b0}}, 1'b1};
        else if ($signed(a_q) < $signed(b_q))  alu_y = '1;
        else                                   alu_y = '0;
      end
      4'h5:    alu_y = a_q & b_q;
      4'h6:    alu_y = a_q | b_q;
      4'h7:    alu_y = a_q ^ b_q;
      4'h8:    alu_y = ~(a_q & b_q);
      4'h9:    alu_y = ~(a_q | b_q);
      4'hA:    alu_y = ~a_q;
      default: alu_y = '0;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_sum, prod;
  logic               mul_ovf;

  // Multiply sign-magnitude: |-(2^(WIDTH-1))| still fits in WIDTH unsigned bits.
  assign mag_a   = a_q[WIDTH-1] ? -a_q : a_q;
  assign mag_b   = b_q[WIDTH-1] ? -b_q : b_q;
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod    = neg_q ? -acc_sum : acc_sum;
  assign mul_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
  assign op_ready = (state_q == S_IDLE);
`else
  assign op_ready = 1'b1;
`endif

  assign accept = op_valid && op_ready;

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    flags_d   = flags_q;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
`endif
    if (accept) begin
      valid_d = 1'b1;
      if (alu_upd) begin
        result_d = alu_y;
        flags_d  = {alu_v, alu_c, alu_y[WIDTH-1], (alu_y == '0)};
      end
      case (opcode)
        4'hB: b_d = data_in;
        4'hC: begin
`ifdef SEQ_ALU_MUL_EN
          valid_d  = 1'b0;
          state_d  = S_MUL;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = a_q[WIDTH-1] ^ b_q[WIDTH-1];
`else
          illegal_d = 1'b1;
`endif
        end
        4'hD: a_d = result_q;
        4'hE: begin
          a_d = b_q;
          b_d = a_q;
        end
        4'hF: a_d = data_in;
        default: ;
      endcase
    end
`ifdef SEQ_ALU_MUL_EN
    if (state_q == S_MUL) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH-1)) begin
        result_d = prod[WIDTH-1:0];
        flags_d  = {mul_ovf, 1'b0, prod[WIDTH-1], (prod[WIDTH-1:0] == '0)};
        valid_d  = 1'b1;
        state_d  = S_IDLE;
        cnt_d    = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
`endif
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
`ifdef SEQ_ALU_MUL_EN
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
`endif
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign flags        = flags_q;
  assign illegal      = illegal_q;
  assign a_out        = a_q;
  assign b_out        = b_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_seq_alu : self-checking bench for seq_alu (WIDTH=8 main, WIDTH=16 spot). |
// | Revision   : 1.0                                                            |
// +-----------------------------------------------------------------------------+
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] opcode = 4'h0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] result, a_out, b_out;
  logic       result_valid, illegal;
  logic [3:0] flags;

  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [3:0]  w_opcode = 4'h0;
  logic [15:0] w_data = 16'h0000;
  logic [15:0] w_result, w_a, w_b;
  logic        w_rvalid, w_illegal;
  logic [3:0]  w_flags;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integers holding unsigned 8-bit values.
  int       ma = 0, mb = 0, mres = 0;
  logic [3:0] mflg = 4'h0;
  int       m_ill = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .data_in(data_in), .result(result), .result_valid(result_valid),
    .flags(flags), .illegal(illegal), .a_out(a_out), .b_out(b_out)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .op_valid(w_valid), .op_ready(w_ready),
    .opcode(w_opcode), .data_in(w_data), .result(w_result), .result_valid(w_rvalid),
    .flags(w_flags), .illegal(w_illegal), .a_out(w_a), .b_out(w_b)
  );

  typedef struct {
    int op; int din; int res; int flg; int a; int b;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic bit out8(input int v);
    return (v > 127) || (v < -128);
  endfunction

  task automatic model_apply(input int op, input int din);
    int sa, sb, r, v, c;
    bit upd;
    sa = sx(ma); sb = sx(mb);
    r = 0; v = 0; c = 0; upd = 1'b1; m_ill = 0;
    case (op)
      0:  begin r = ma + mb; c = int'(r > 255); v = int'(out8(sa + sb)); end
      1:  begin r = ma - mb; c = int'(ma < mb); v = int'(out8(sa - sb)); end
      2:  begin r = ma * 2; c = int'(ma >= 128); v = int'(out8(sa * 2)); end
      3:  begin r = (sa - (ma % 2)) / 2; c = ma % 2; end
      4:  r = (sa > sb) ? 1 : ((sa == sb) ? 0 : -1);
      5:  r = ma & mb;
      6:  r = ma | mb;
      7:  r = ma ^ mb;
      8:  r = ~(ma & mb);
      9:  r = ~(ma | mb);
      10: r = ~ma;
      11: begin mb = din; upd = 1'b0; end
      12: begin upd = 1'b0; m_ill = 1; end
      13: begin ma = mres; upd = 1'b0; end
      14: begin r = ma; ma = mb; mb = r; upd = 1'b0; end
      default: begin ma = din; upd = 1'b0; end
    endcase
    if (upd) begin
      mres = r & 255;
      mflg = {v != 0, c != 0, mres >= 128, mres == 0};
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_result"}, int'(result), mres);
    chk({tag, "_flags"}, int'(flags), int'(mflg));
    chk({tag, "_a"}, int'(a_out), ma);
    chk({tag, "_b"}, int'(b_out), mb);
  endtask

  task automatic do_cmd(input int op, input int din);
    op_valid = 1'b1; opcode = 4'(op); data_in = 8'(din);
    @(posedge clk); #1;
    op_valid = 1'b0;
    model_apply(op, din);
    chk("cmd_valid", int'(result_valid), 1);
    chk("cmd_illegal", int'(illegal), m_ill);
    chk("cmd_ready", int'(op_ready), 1);
    chk_state("cmd");
  endtask

  task automatic idle();
    op_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", int'(result_valid), 0);
    chk("idle_illegal", int'(illegal), 0);
    chk_state("idle");
  endtask

`ifdef SEQ_ALU_MUL_EN
  task automatic do_mul();
    int p;
    p = sx(ma) * sx(mb);
    op_valid = 1'b1; opcode = 4'hC; data_in = 8'($urandom);
    @(posedge clk); #1;
    chk("mul_ready_drop", int'(op_ready), 0);
    chk("mul_valid_low", int'(result_valid), 0);
    for (int i = 1; i <= 8; i++) begin
      // Commands offered while busy must be dropped.
      op_valid = 1'($urandom_range(0, 1));
      opcode   = 4'($urandom);
      data_in  = 8'($urandom);
      @(posedge clk); #1;
      if (i < 8) begin
        chk("mul_busy_ready", int'(op_ready), 0);
        chk("mul_busy_valid", int'(result_valid), 0);
        chk("mul_busy_a", int'(a_out), ma);
        chk("mul_busy_b", int'(b_out), mb);
      end
    end
    op_valid = 1'b0;
    mres = p & 255;
    mflg = {out8(p), 1'b0, mres >= 128, mres == 0};
    chk("mul_done_valid", int'(result_valid), 1);
    chk("mul_done_ready", int'(op_ready), 1);
    chk("mul_done_illegal", int'(illegal), 0);
    chk_state("mul");
  endtask
`endif

  task automatic w16_cmd(input int op, input int din);
    w_valid = 1'b1; w_opcode = 4'(op); w_data = 16'(din);
    @(posedge clk); #1;
    w_valid = 1'b0;
    chk("w16_valid", int'(w_rvalid), 1);
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{15, 'h7F, 'h00, 4'b0000, 'h7F, 'h00};
    tbl[1]  = '{11, 'h01, 'h00, 4'b0000, 'h7F, 'h01};
    tbl[2]  = '{0,  'h00, 'h80, 4'b1010, 'h7F, 'h01};
    tbl[3]  = '{15, 'h05, 'h80, 4'b1010, 'h05, 'h01};
    tbl[4]  = '{11, 'h05, 'h80, 4'b1010, 'h05, 'h05};
    tbl[5]  = '{4,  'h00, 'h00, 4'b0001, 'h05, 'h05};
    tbl[6]  = '{15, 'h80, 'h00, 4'b0001, 'h80, 'h05};
    tbl[7]  = '{11, 'h01, 'h00, 4'b0001, 'h80, 'h01};
    tbl[8]  = '{4,  'h00, 'hFF, 4'b0010, 'h80, 'h01};
    tbl[9]  = '{15, 'h81, 'hFF, 4'b0010, 'h81, 'h01};
    tbl[10] = '{3,  'h00, 'hC0, 4'b0110, 'h81, 'h01};
    tbl[11] = '{15, 'h12, 'hC0, 4'b0110, 'h12, 'h01};
    tbl[12] = '{11, 'h34, 'hC0, 4'b0110, 'h12, 'h34};
    tbl[13] = '{14, 'h00, 'hC0, 4'b0110, 'h34, 'h12};
    tbl[14] = '{13, 'h00, 'hC0, 4'b0110, 'hC0, 'h12};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(op_ready), 1);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_illegal", int'(illegal), 0);
    chk_state("rst");
    reset = 1'b0;
    idle();

    for (int i = 0; i < 15; i++) begin
      do_cmd(tbl[i].op, tbl[i].din);
      chk("tbl_result", int'(result), tbl[i].res);
      chk("tbl_flags", int'(flags), tbl[i].flg);
      chk("tbl_a", int'(a_out), tbl[i].a);
      chk("tbl_b", int'(b_out), tbl[i].b);
    end
    idle();

`ifdef SEQ_ALU_MUL_EN
    do_cmd(15, 'hFD); do_cmd(11, 'h07);
    do_mul();
    chk("mul_neg21", int'(result), 'hEB);
    chk("mul_neg21_flags", int'(flags), 4'b0010);
    do_cmd(15, 'h40); do_cmd(11, 'h04);
    do_mul();
    chk("mul_ovf_flags", int'(flags), 4'b1001);
    do_cmd(15, 'h80); do_cmd(11, 'h80);
    do_mul();
`else
    do_cmd(12, 'h55);
    chk("nomul_illegal", int'(illegal), 1);
    chk("nomul_result", int'(result), 'hC0);
    idle();
`endif

    for (int n = 0; n < 300; n++) begin
      int op;
      op = $urandom_range(0, 15);
`ifdef SEQ_ALU_MUL_EN
      if (op == 12) do_mul();
      else          do_cmd(op, int'($urandom_range(0, 255)));
`else
      do_cmd(op, int'($urandom_range(0, 255)));
`endif
      if ($urandom_range(0, 3) == 0) idle();
    end

    // Asynchronous reset in the middle of a busy period.
    do_cmd(15, 'h03); do_cmd(11, 'h05);
`ifdef SEQ_ALU_MUL_EN
    op_valid = 1'b1; opcode = 4'hC;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (2) @(posedge clk);
`endif
    #1 reset = 1'b1;
    #1;
    ma = 0; mb = 0; mres = 0; mflg = 4'h0;
    chk("amid_ready", int'(op_ready), 1);
    chk("amid_valid", int'(result_valid), 0);
    chk_state("amid");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) idle();
    do_cmd(15, 'h03); do_cmd(11, 'h05); do_cmd(0, 0);
    chk("post_rst_add", int'(result), 'h08);

    chk("w16_rst_ready", int'(w_ready), 1);
    w16_cmd(15, 'h7FFF); w16_cmd(11, 'h0001); w16_cmd(0, 0);
    chk("w16_add_result", int'(w_result), 'h8000);
    chk("w16_add_flags", int'(w_flags), 4'b1010);
    w16_cmd(1, 0);
    chk("w16_sub_result", int'(w_result), 'h7FFE);
    chk("w16_sub_flags", int'(w_flags), 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
